// File: rtl/iiitb_gray_cntr.sv
// iiitb_gray_cntr: free-running binary counter with a registered reflected-binary Gray copy.
module iiitb_gray_cntr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] bcd_value,
  output logic [WIDTH-1:0] gray_count
);
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_next;
  assign w_next = r_bin + {{(WIDTH-1){1'b0}}, 1'b1};
  // Gray is derived from the next binary value so both registers always agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_next;
      r_gray <= w_next ^ (w_next >> 1);
    end
  end
  assign bcd_value  = r_bin;
  assign gray_count = r_gray;
endmodule

// File: tb/tb_iiitb_gray_cntr.sv
// tb_iiitb_gray_cntr: table and scoreboard checks of the 4-bit Gray counter.
module tb_iiitb_gray_cntr;
  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd_value;
  logic [3:0] gray_count;
  logic [3:0] m;
  logic [3:0] prev_gray;
  logic [3:0] gl [16];
  exp_t       tbl [16];
  exp_t       sbq [$];
  int         total = 0;
  int         bad = 0;
  iiitb_gray_cntr #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bcd_value(bcd_value),
    .gray_count(gray_count)
  );
  always #10 clk = ~clk;
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask
  task automatic chk_i(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_bin"}, bcd_value, 4'h0);
    chk({nm, "_gray"}, gray_count, 4'h0);
  endtask
  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      bad++;
      total++;
      $display("FAIL %s: got empty scoreboard want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_bin"}, bcd_value, e.bin);
      chk({nm, "_gray"}, gray_count, e.gray);
    end
  endtask
  task automatic step(input string nm);
    exp_t e;
    m = m + 4'd1;
    e.bin = m;
    e.gray = gl[m];
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    pop_cmp(nm);
  endtask
  initial begin
    int d;
    gl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    tbl = '{'{4'd1, 4'h1}, '{4'd2, 4'h3}, '{4'd3, 4'h2}, '{4'd4, 4'h6},
            '{4'd5, 4'h7}, '{4'd6, 4'h5}, '{4'd7, 4'h4}, '{4'd8, 4'hC},
            '{4'd9, 4'hD}, '{4'd10, 4'hF}, '{4'd11, 4'hE}, '{4'd12, 4'hA},
            '{4'd13, 4'hB}, '{4'd14, 4'h9}, '{4'd15, 4'h8}, '{4'd0, 4'h0}};
    @(negedge clk);
    chk_zero("rst_hold0");
    @(negedge clk);
    chk_zero("rst_hold1");
    rst = 1'b1;
    m = 4'd0;
    for (int i = 0; i < 16; i++) begin
      sbq.push_back(tbl[i]);
      m = m + 4'd1;
      @(posedge clk);
      @(negedge clk);
      pop_cmp($sformatf("seq%0d", i));
    end
    prev_gray = gray_count;
    for (int i = 0; i < 40; i++) begin
      step($sformatf("run%0d", i));
      chk_i($sformatf("onebit%0d", i), $countones(prev_gray ^ gray_count), 1);
      prev_gray = gray_count;
    end
    for (int i = 0; i < 16 && m != 4'd7; i++) step("to7");
    #3 rst = 1'b0;
    #1 chk_zero("async_clr");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero($sformatf("rst_mid%0d", i));
    end
    rst = 1'b1;
    m = 4'd0;
    step("after_rel");
    for (int i = 0; i < 16 && m != 4'd15; i++) step("to15");
    step("wrap0");
    step("wrap1");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) step($sformatf("rnd%0d", k));
      d = int'($urandom_range(2, 6));
      #(d) rst = 1'b0;
      #1 chk_zero($sformatf("rnd_clr%0d", k));
      @(posedge clk);
      #1 chk_zero($sformatf("rnd_hold%0d", k));
      d = int'($urandom_range(3, 7));
      #(d) rst = 1'b1;
      m = 4'd0;
      step($sformatf("rnd_rel%0d", k));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
